// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: validates size/alignment, runs one word-addressed
// memory handshake with a bounded ack wait, and returns extended load data.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_cause,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_ACCESS = 2'b01, S_DONE = 2'b10} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state_r, state_s;
  logic [15:0] cnt_r, cnt_s;
  logic [2:0]  f3_r, f3_s;
  logic [1:0]  off_r, off_s;
  logic [31:0] rdata_r, rdata_s, mem_addr_r, mem_addr_s, mem_wdata_r, mem_wdata_s;
  logic        done_r, done_s, err_r, err_s, busy_r, busy_s;
  logic        mem_req_r, mem_req_s, mem_we_r, mem_we_s;
  logic [1:0]  cause_r, cause_s;
  logic [3:0]  mem_wmask_r, mem_wmask_s;
  logic        illegal_s, misaligned_s;
  logic [31:0] shifted_s, load_val_s;

  // Request legality: stores allow only B/H/W, loads additionally BU/HU.
  always_comb begin
    illegal_s    = 1'b0;
    misaligned_s = 1'b0;
    if (we) begin
      illegal_s = funct3[2] || (funct3 == 3'b011);
    end else begin
      illegal_s = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end
    case (funct3[1:0])
      2'b01:   misaligned_s = addr[0];
      2'b10:   misaligned_s = (addr[1:0] != 2'b00);
      default: misaligned_s = 1'b0;
    endcase
  end

  // Load lane extraction and sign/zero extension from the captured size/offset.
  always_comb begin
    shifted_s = mem_rdata >> {off_r, 3'b000};
    case (f3_r)
      3'b000:  load_val_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
      3'b001:  load_val_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
      3'b010:  load_val_s = mem_rdata;
      3'b100:  load_val_s = {24'h000000, shifted_s[7:0]};
      3'b101:  load_val_s = {16'h0000, shifted_s[15:0]};
      default: load_val_s = 32'h0000_0000;
    endcase
  end

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    f3_s        = f3_r;
    off_s       = off_r;
    rdata_s     = rdata_r;
    done_s      = 1'b0;
    err_s       = err_r;
    cause_s     = cause_r;
    mem_req_s   = mem_req_r;
    mem_we_s    = mem_we_r;
    mem_addr_s  = mem_addr_r;
    mem_wmask_s = mem_wmask_r;
    mem_wdata_s = mem_wdata_r;
    case (state_r)
      S_IDLE: begin
        if (req) begin
          if (illegal_s || misaligned_s) begin
            state_s = S_DONE;
            done_s  = 1'b1;
            err_s   = 1'b1;
            cause_s = illegal_s ? 2'b10 : 2'b01;
            rdata_s = 32'h0000_0000;
          end else begin
            state_s    = S_ACCESS;
            cnt_s      = 16'h0000;
            f3_s       = funct3;
            off_s      = addr[1:0];
            rdata_s    = 32'h0000_0000;
            err_s      = 1'b0;
            cause_s    = 2'b00;
            mem_req_s  = 1'b1;
            mem_we_s   = we;
            mem_addr_s = {addr[31:2], 2'b00};
            case (funct3[1:0])
              2'b00: begin
                mem_wmask_s = we ? (4'b0001 << addr[1:0]) : 4'b0000;
                mem_wdata_s = {4{wdata[7:0]}};
              end
              2'b01: begin
                mem_wmask_s = we ? (4'b0011 << addr[1:0]) : 4'b0000;
                mem_wdata_s = {2{wdata[15:0]}};
              end
              default: begin
                mem_wmask_s = we ? 4'b1111 : 4'b0000;
                mem_wdata_s = wdata;
              end
            endcase
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (mem_ack || (cnt_r == TO_LAST)) begin
          state_s     = S_DONE;
          done_s      = 1'b1;
          err_s       = !mem_ack;
          cause_s     = mem_ack ? 2'b00 : 2'b11;
          rdata_s     = (mem_ack && !mem_we_r) ? load_val_s : 32'h0000_0000;
          mem_req_s   = 1'b0;
          mem_we_s    = 1'b0;
          mem_addr_s  = 32'h0000_0000;
          mem_wmask_s = 4'b0000;
          mem_wdata_s = 32'h0000_0000;
        end else begin
          cnt_s = cnt_r + 16'h0001;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
    busy_s = (state_s != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      cnt_r       <= 16'h0000;
      f3_r        <= 3'b000;
      off_r       <= 2'b00;
      rdata_r     <= 32'h0000_0000;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      cause_r     <= 2'b00;
      busy_r      <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_wmask_r <= 4'b0000;
      mem_wdata_r <= 32'h0000_0000;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      f3_r        <= f3_s;
      off_r       <= off_s;
      rdata_r     <= rdata_s;
      done_r      <= done_s;
      err_r       <= err_s;
      cause_r     <= cause_s;
      busy_r      <= busy_s;
      mem_req_r   <= mem_req_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wmask_r <= mem_wmask_s;
      mem_wdata_r <= mem_wdata_s;
    end
  end

  assign rdata     = rdata_r;
  assign done      = done_r;
  assign err       = err_r;
  assign err_cause = cause_r;
  assign busy      = busy_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wmask = mem_wmask_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with TIMEOUT=4; hand-computed expectations.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst, req, we, mem_ack;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_rdata;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic        done, err, busy, mem_req, mem_we;
  logic [1:0]  err_cause;
  logic [3:0]  mem_wmask;
  int          nvec = 0;
  int          nerr = 0;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .rdata(rdata), .done(done), .err(err), .err_cause(err_cause),
    .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns in the first cycle after acceptance.
  task automatic send(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
    step();
    req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0;
    wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_memreq", {31'h0, mem_req}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);

    // LB 0x103, ack in 4th ACCESS cycle -> done 5 cycles after req
    send(1'b0, 3'b000, 32'h0000_0103, 32'h0);
    mem_rdata = 32'h8000_0000;
    chk("lb_memreq", {31'h0, mem_req}, 32'h1);
    chk("lb_memaddr", mem_addr, 32'h0000_0100);
    chk("lb_mask", {28'h0, mem_wmask}, 32'h0);
    chk("lb_busy", {31'h0, busy}, 32'h1);
    req = 1'b1; addr = 32'h0000_0900;
    step();
    req = 1'b0;
    step();
    chk("lb_ignore_req", mem_addr, 32'h0000_0100);
    step();
    chk("lb_nodone_early", {31'h0, done}, 32'h0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("lb_done", {31'h0, done}, 32'h1);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    chk("lb_err", {31'h0, err}, 32'h0);
    chk("lb_busy_hold", {31'h0, busy}, 32'h1);
    step();
    chk("lb_done_pulse", {31'h0, done}, 32'h0);
    chk("lb_busy_fall", {31'h0, busy}, 32'h0);
    chk("lb_rdata_held", rdata, 32'hFFFF_FF80);

    // LHU 0x202, zero-wait
    send(1'b0, 3'b101, 32'h0000_0202, 32'h0);
    mem_rdata = 32'hBEEF_1234; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("lhu_done", {31'h0, done}, 32'h1);
    chk("lhu_rdata", rdata, 32'h0000_BEEF);
    step();

    // LH 0x000 sign extension
    send(1'b0, 3'b001, 32'h0000_0000, 32'h0);
    mem_rdata = 32'h0000_8001; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("lh_rdata", rdata, 32'hFFFF_8001);
    step();

    // SB 0x301
    send(1'b1, 3'b000, 32'h0000_0301, 32'h0000_00A5);
    chk("sb_mask", {28'h0, mem_wmask}, 32'h2);
    chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("sb_we", {31'h0, mem_we}, 32'h1);
    chk("sb_addr", mem_addr, 32'h0000_0300);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("sb_done", {31'h0, done}, 32'h1);
    chk("sb_rdata", rdata, 32'h0);
    chk("sb_memreq_low", {31'h0, mem_req}, 32'h0);
    chk("sb_mask_low", {28'h0, mem_wmask}, 32'h0);
    step();

    // SH 0x302 and SW 0x300
    send(1'b1, 3'b001, 32'h0000_0302, 32'h1234_CAFE);
    chk("sh_mask", {28'h0, mem_wmask}, 32'hC);
    chk("sh_wdata", mem_wdata, 32'hCAFE_CAFE);
    mem_ack = 1'b1; step(); mem_ack = 1'b0; step();
    send(1'b1, 3'b010, 32'h0000_0300, 32'h1234_5678);
    chk("sw_mask", {28'h0, mem_wmask}, 32'hF);
    chk("sw_wdata", mem_wdata, 32'h1234_5678);
    mem_ack = 1'b1; step(); mem_ack = 1'b0;
    chk("sw_err", {31'h0, err}, 32'h0);
    step();

    // LW misaligned and SB with funct3=100
    send(1'b0, 3'b010, 32'h0000_0402, 32'h0);
    chk("mis_done", {31'h0, done}, 32'h1);
    chk("mis_err", {31'h0, err}, 32'h1);
    chk("mis_cause", {30'h0, err_cause}, 32'h1);
    chk("mis_memreq", {31'h0, mem_req}, 32'h0);
    chk("mis_rdata", rdata, 32'h0);
    step();
    chk("mis_memreq2", {31'h0, mem_req}, 32'h0);
    chk("mis_busy", {31'h0, busy}, 32'h0);
    send(1'b1, 3'b100, 32'h0000_0300, 32'h0);
    chk("ill_done", {31'h0, done}, 32'h1);
    chk("ill_cause", {30'h0, err_cause}, 32'h2);
    chk("ill_memreq", {31'h0, mem_req}, 32'h0);
    step();

    // Timeout: mem_req high 4 cycles then done with cause 11
    send(1'b0, 3'b010, 32'h0000_0500, 32'h0);
    mem_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      chk("to_memreq", {31'h0, mem_req}, 32'h1);
      chk("to_nodone", {31'h0, done}, 32'h0);
      step();
    end
    chk("to_done", {31'h0, done}, 32'h1);
    chk("to_err", {31'h0, err}, 32'h1);
    chk("to_cause", {30'h0, err_cause}, 32'h3);
    chk("to_memreq_low", {31'h0, mem_req}, 32'h0);
    chk("to_rdata", rdata, 32'h0);
    step();

    // Ack on the 4th ACCESS cycle beats the timeout
    send(1'b0, 3'b010, 32'h0000_0500, 32'h0);
    step(); step(); step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("ackwin_done", {31'h0, done}, 32'h1);
    chk("ackwin_err", {31'h0, err}, 32'h0);
    chk("ackwin_cause", {30'h0, err_cause}, 32'h0);
    chk("ackwin_rdata", rdata, 32'hDEAD_BEEF);
    step();

    // Reset in 2nd ACCESS cycle, late ack ignored
    send(1'b0, 3'b010, 32'h0000_0600, 32'h0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_memreq", {31'h0, mem_req}, 32'h0);
    chk("mrst_busy", {31'h0, busy}, 32'h0);
    chk("mrst_addr", mem_addr, 32'h0);
    chk("mrst_rdata", rdata, 32'h0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("mrst_nodone", {31'h0, done}, 32'h0);
    chk("mrst_memreq2", {31'h0, mem_req}, 32'h0);
    step();
    chk("mrst_nodone2", {31'h0, done}, 32'h0);

    // Fresh LW after reset
    send(1'b0, 3'b010, 32'h0000_0700, 32'h0);
    chk("post_memaddr", mem_addr, 32'h0000_0700);
    mem_rdata = 32'h1122_3344; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("post_done", {31'h0, done}, 32'h1);
    chk("post_rdata", rdata, 32'h1122_3344);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit between the CPU's memory stage and the data memory. It accepts one load or store request from the CPU, checks alignment and access size, drives a word-addressed memory handshake with byte write-enables, waits for acknowledge with a bounded timeout, and returns sign- or zero-extended load data. The CPU state machine holds its memory stage until `done` pulses.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent waiting for `mem_ack` before the access is aborted; range 1..65535.
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `req`  input  1  request strobe from CPU memory stage; sampled only in IDLE.
- `we`  input  1  1 = store, 0 = load; sampled with `req`.
- `funct3`  input  3  RISC-V size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
- `addr`  input  32  byte address; sampled with `req`.
- `wdata`  input  32  store data, low bits significant; sampled with `req`.
- `rdata`  output  32  extended load data; valid when `done`=1, held until next accepted request.
- `done`  output  1  one-cycle completion pulse.
- `err`  output  1  access failed; valid with `done`, held like `rdata`.
- `err_cause`  output  2  00 none, 01 misaligned, 10 illegal funct3, 11 timeout.
- `busy`  output  1  high whenever state is not IDLE.
- `mem_req`  output  1  memory request; held high until ack or timeout.
- `mem_we`  output  1  memory write enable.
- `mem_addr`  output  32  word address, `{addr[31:2],2'b00}`.
- `mem_wmask`  output  4  byte-lane write enables; 0000 for loads.
- `mem_wdata`  output  32  lane-replicated store data.
- `mem_rdata`  input  32  memory read word; sampled on the cycle `mem_ack`=1.
- `mem_ack`  input  1  memory completion; ignored unless state is ACCESS.

## Operation
- States: IDLE, ACCESS, DONE. IDLE→ACCESS on legal aligned `req`; IDLE→DONE on illegal or misaligned `req` (no memory access); ACCESS→DONE on `mem_ack` or timeout; DONE→IDLE unconditionally.
- Checks in priority order: illegal funct3 (store with 1xx or 011; load with 011, 110, 111) → cause 10; then misaligned (H/HU with addr[0]=1; W with addr[1:0]≠00) → cause 01.
- Store lanes: B: mask `0001<<addr[1:0]`, data `{4{wdata[7:0]}}`; H: mask `0011<<addr[1:0]`, data `{2{wdata[15:0]}}`; W: mask 1111, data `wdata`.
- Load extract: byte = `mem_rdata[8*addr[1:0] +: 8]`; half = `mem_rdata[8*addr[1:0] +: 16]`; B/H sign-extend, BU/HU zero-extend, W passthrough.
- Stores leave `rdata` at 0 on completion; errored requests set `rdata` to 0.
- All outputs are registered. `req` while `busy` is ignored (not queued).
- Timeout counter is 16 bits, cleared on entry to ACCESS and incremented each ACCESS cycle without ack. When it reaches TIMEOUT-1 without ack, the access ends with cause 11. If ack arrives on the same cycle, ack wins.
- `mem_req`, `mem_we`, `mem_addr`, `mem_wmask`, `mem_wdata` are constant throughout ACCESS. Outside ACCESS, `mem_req`=0 and `mem_wmask`=0000.

## Timing
- Reset (rst=1 at an edge) forces IDLE and sets every output to 0. This also applies mid-ACCESS: `mem_req` is low from the cycle after the reset edge, and a late `mem_ack` is then ignored.
- Request accepted at edge N → `mem_req`=1 in cycle N+1.
- `mem_ack` sampled at edge M → `done`=1 in cycle M+1 with `rdata`/`err` valid; `busy` falls in cycle M+2.
- Zero-wait memory (ack in the first ACCESS cycle) gives 2 cycles from `req` to `done`.
- Error path: `req` at edge N → `done`=1, `err`=1 in cycle N+1, with no `mem_req`.
- Timeout: `done` in cycle N+1+TIMEOUT if no ack ever arrives.
- A back-to-back `req` is accepted earliest in the cycle after `done`.

## Test plan
- LB at addr 0x103, `mem_rdata`=0x80_00_00_00, ack after 3 cycles → `mem_addr`=0x100, `rdata`=0xFFFFFF80, `err`=0, `done` 5 cycles after `req`.
- LHU at 0x202 with `mem_rdata`=0xBEEF1234, zero-wait ack → `rdata`=0x0000BEEF, `done` exactly 2 cycles after `req`.
- SB at 0x301, `wdata`=0x000000A5 → `mem_wmask`=0010, `mem_wdata`=0xA5A5A5A5, `mem_we`=1; SW at 0x300 → mask 1111.
- LW at 0x402 → `done`, `err`=1, `err_cause`=01 in the next cycle; `mem_req` never rises. SB with funct3=100 → `err_cause`=10.
- TIMEOUT=4, LW with no ack → `mem_req` high for 4 cycles, then `done`, `err_cause`=11. Repeat with ack on the 4th cycle → success, `err`=0.
- Assert `rst` in the 2nd ACCESS cycle, then ack one cycle later → all outputs 0, `done` never pulses. A new LW is accepted normally after reset.
